// File: rtl/controlador_partida_pkg.sv
// Shared definitions for the battleship game controller: state codes, LED codes,
// board geometry and the (column,row) -> bit index mapping.
package pacote_batalha_naval;

  typedef enum logic [2:0] {
    OCIOSO         = 3'd0,
    POSICIONAMENTO = 3'd1,
    ATAQUE         = 3'd2,
    AVALIA         = 3'd3,
    VITORIA        = 3'd4,
    DERROTA        = 3'd5
  } estado_t;

  localparam logic [1:0] LED_APAGADO  = 2'b00;
  localparam logic [1:0] LED_AGUA     = 2'b01;
  localparam logic [1:0] LED_ACERTO   = 2'b10;
  localparam logic [1:0] LED_INVALIDO = 2'b11;

  localparam int NUM_COLUNAS = 5;
  localparam int NUM_LINHAS  = 7;
  localparam int NUM_CELULAS = NUM_COLUNAS * NUM_LINHAS;

  localparam logic [NUM_LINHAS-1:0]  SETE_ALTOS  = 7'h7F;
  localparam logic [NUM_CELULAS-1:0] TODOS_ALTOS = {NUM_COLUNAS{SETE_ALTOS}};

  function automatic logic [5:0] indice(input logic [2:0] c, input logic [2:0] l);
    return (({3'b000, c} - 6'd1) * 6'd7) + ({3'b000, l} - 6'd1);
  endfunction

  function automatic logic coordenada_valida(input logic [2:0] c, input logic [2:0] l);
    return (c >= 3'd1) && (c <= 3'd5) && (l >= 3'd1) && (l <= 3'd7);
  endfunction

endpackage

// File: rtl/controlador_partida_if.sv
// Board-side signal bundle of the game controller: switches/buttons in, LED-matrix
// column drive and status out. master = board/stimulus side, slave = controller.
interface controlador_partida_if;
  logic        ligado;
  logic        modo;
  logic        salvar_jogo;
  logic        confirmar_ataque;
  logic [2:0]  ataque_colunas;
  logic [2:0]  ataque_linhas;
  logic [34:0] tabuleiro_posicionamento;
  logic [34:0] tabuleiro_saida;
  logic [1:0]  ledRGB;
  logic [2:0]  estado;
  logic [5:0]  acertos;
  logic [4:0]  tentativas_restantes;
  logic        fim_de_jogo;
  logic        vitoria;

  modport master (
    output ligado, modo, salvar_jogo, confirmar_ataque,
           ataque_colunas, ataque_linhas, tabuleiro_posicionamento,
    input  tabuleiro_saida, ledRGB, estado, acertos,
           tentativas_restantes, fim_de_jogo, vitoria
  );

  modport slave (
    input  ligado, modo, salvar_jogo, confirmar_ataque,
           ataque_colunas, ataque_linhas, tabuleiro_posicionamento,
    output tabuleiro_saida, ledRGB, estado, acertos,
           tentativas_restantes, fim_de_jogo, vitoria
  );
endinterface

// File: rtl/controlador_partida_detector_borda.sv
// Rising-edge detector for a level button: one sample register plus the previous
// sample; the pulse lasts exactly one cycle per low-to-high transition.
module detector_borda (
  input  logic clock,
  input  logic reset,
  input  logic entrada,
  output logic borda
);

  logic amostra_q, amostra_d;
  logic anterior_q, anterior_d;

  always_comb begin
    amostra_d  = entrada;
    anterior_d = amostra_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      amostra_q  <= 1'b0;
      anterior_q <= 1'b0;
    end else begin
      amostra_q  <= amostra_d;
      anterior_q <= anterior_d;
    end
  end

  assign borda = amostra_q & ~anterior_q;

endmodule

// File: rtl/controlador_partida.sv
// Battleship game-flow controller: positioning/attack/end-of-game FSM, saved fleet,
// hit/tried maps and counters. Optional end-of-game blink under PISCAR_FIM_EN.
module controlador_partida
  import pacote_batalha_naval::*;
#(
  parameter int MAX_TENTATIVAS = 15,
  parameter int PISCA_CICLOS   = 25_000_000
) (
  input logic                  clock,
  input logic                  reset,
  controlador_partida_if.slave bus
);

  if (MAX_TENTATIVAS < 1 || MAX_TENTATIVAS > 31 || PISCA_CICLOS < 1) begin : g_param_invalido
    $error("controlador_partida: parametro fora da faixa");
  end

  localparam logic [4:0] TENT_INICIAL = 5'(MAX_TENTATIVAS);

  estado_t     estado_q, estado_d;
  logic [34:0] salvo_q, salvo_d;
  logic [34:0] mapa_q, mapa_d;
  logic [34:0] tentado_q, tentado_d;
  logic [34:0] saida_q, saida_d;
  logic [5:0]  acertos_q, acertos_d;
  logic [5:0]  navios_q, navios_d;
  logic [4:0]  tent_q, tent_d;
  logic        jogo_salvo_q, jogo_salvo_d;
  logic [1:0]  led_q, led_d;
  logic [2:0]  col_q, col_d;
  logic [2:0]  lin_q, lin_d;

  logic        salvar_borda, confirmar_borda;
  logic [5:0]  idx;
  logic [5:0]  navios_novos;
  logic        apagar;

  detector_borda u_borda_salvar (
    .clock   (clock),
    .reset   (reset),
    .entrada (bus.salvar_jogo),
    .borda   (salvar_borda)
  );

  detector_borda u_borda_confirmar (
    .clock   (clock),
    .reset   (reset),
    .entrada (bus.confirmar_ataque),
    .borda   (confirmar_borda)
  );

  // Ship cells are active low, so the fleet size is the number of zero bits.
  function automatic logic [5:0] conta_zeros(input logic [34:0] v);
    logic [5:0] n;
    n = 6'd0;
    for (int i = 0; i < 35; i++) begin
      if (!v[i]) n = n + 6'd1;
    end
    return n;
  endfunction

  always_comb begin
    estado_d     = estado_q;
    salvo_d      = salvo_q;
    mapa_d       = mapa_q;
    tentado_d    = tentado_q;
    acertos_d    = acertos_q;
    navios_d     = navios_q;
    tent_d       = tent_q;
    jogo_salvo_d = jogo_salvo_q;
    led_d        = led_q;
    col_d        = col_q;
    lin_d        = lin_q;
    idx          = indice(col_q, lin_q);
    navios_novos = conta_zeros(bus.tabuleiro_posicionamento);

    case (estado_q)
      OCIOSO: estado_d = POSICIONAMENTO;

      // A save edge takes the whole cycle; a pending mode change is honoured next cycle.
      POSICIONAMENTO: begin
        if (salvar_borda) begin
          if (navios_novos != 6'd0) begin
            salvo_d      = bus.tabuleiro_posicionamento;
            navios_d     = navios_novos;
            mapa_d       = TODOS_ALTOS;
            tentado_d    = '0;
            acertos_d    = 6'd0;
            tent_d       = TENT_INICIAL;
            jogo_salvo_d = 1'b1;
          end
        end else if (bus.modo && jogo_salvo_q) begin
          estado_d = ATAQUE;
        end
      end

      ATAQUE: begin
        if (!bus.modo) begin
          estado_d = POSICIONAMENTO;
        end else if (confirmar_borda) begin
          col_d    = bus.ataque_colunas;
          lin_d    = bus.ataque_linhas;
          estado_d = AVALIA;
        end
      end

      AVALIA: begin
        if (!coordenada_valida(col_q, lin_q) || tentado_q[idx]) begin
          led_d = LED_INVALIDO;
        end else if (!salvo_q[idx]) begin
          mapa_d[idx]    = 1'b0;
          tentado_d[idx] = 1'b1;
          acertos_d      = acertos_q + 6'd1;
          led_d          = LED_ACERTO;
        end else begin
          tentado_d[idx] = 1'b1;
          if (tent_q != 5'd0) tent_d = tent_q - 5'd1;
          led_d          = LED_AGUA;
        end
        if (acertos_d == navios_q)  estado_d = VITORIA;
        else if (tent_d == 5'd0)    estado_d = DERROTA;
        else                        estado_d = ATAQUE;
      end

      VITORIA, DERROTA: begin
        if (!bus.modo) estado_d = POSICIONAMENTO;
      end

      default: estado_d = OCIOSO;
    endcase

    // Power-off wins over everything, including an evaluation in flight.
    if (!bus.ligado) begin
      estado_d     = OCIOSO;
      salvo_d      = TODOS_ALTOS;
      mapa_d       = TODOS_ALTOS;
      tentado_d    = '0;
      acertos_d    = 6'd0;
      navios_d     = 6'd0;
      tent_d       = TENT_INICIAL;
      jogo_salvo_d = 1'b0;
      col_d        = 3'd0;
      lin_d        = 3'd0;
    end

    case (estado_d)
      OCIOSO, POSICIONAMENTO: led_d = LED_APAGADO;
      VITORIA:                led_d = LED_ACERTO;
      DERROTA:                led_d = LED_AGUA;
      default:                ;
    endcase

    case (estado_d)
      OCIOSO:         saida_d = TODOS_ALTOS;
      POSICIONAMENTO: saida_d = bus.tabuleiro_posicionamento;
      default:        saida_d = apagar ? TODOS_ALTOS : mapa_d;
    endcase
  end

`ifdef PISCAR_FIM_EN
  localparam int PW = $clog2(PISCA_CICLOS + 1);

  logic [PW-1:0] pisca_cnt_q, pisca_cnt_d;
  logic          fase_q, fase_d;
  logic          fim_agora, fim_antes;

  always_comb begin
    fim_agora   = (estado_d == VITORIA) || (estado_d == DERROTA);
    fim_antes   = (estado_q == VITORIA) || (estado_q == DERROTA);
    pisca_cnt_d = '0;
    fase_d      = 1'b0;
    if (fim_agora && fim_antes) begin
      if (pisca_cnt_q == PW'(PISCA_CICLOS - 1)) begin
        pisca_cnt_d = '0;
        fase_d      = ~fase_q;
      end else begin
        pisca_cnt_d = pisca_cnt_q + 1'b1;
        fase_d      = fase_q;
      end
    end
    apagar = fim_agora && fase_d;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pisca_cnt_q <= '0;
      fase_q      <= 1'b0;
    end else begin
      pisca_cnt_q <= pisca_cnt_d;
      fase_q      <= fase_d;
    end
  end
`else
  assign apagar = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      estado_q     <= OCIOSO;
      salvo_q      <= TODOS_ALTOS;
      mapa_q       <= TODOS_ALTOS;
      tentado_q    <= '0;
      saida_q      <= TODOS_ALTOS;
      acertos_q    <= 6'd0;
      navios_q     <= 6'd0;
      tent_q       <= TENT_INICIAL;
      jogo_salvo_q <= 1'b0;
      led_q        <= LED_APAGADO;
      col_q        <= 3'd0;
      lin_q        <= 3'd0;
    end else begin
      estado_q     <= estado_d;
      salvo_q      <= salvo_d;
      mapa_q       <= mapa_d;
      tentado_q    <= tentado_d;
      saida_q      <= saida_d;
      acertos_q    <= acertos_d;
      navios_q     <= navios_d;
      tent_q       <= tent_d;
      jogo_salvo_q <= jogo_salvo_d;
      led_q        <= led_d;
      col_q        <= col_d;
      lin_q        <= lin_d;
    end
  end

  assign bus.tabuleiro_saida      = saida_q;
  assign bus.ledRGB               = led_q;
  assign bus.estado               = estado_q;
  assign bus.acertos              = acertos_q;
  assign bus.tentativas_restantes = tent_q;
  assign bus.fim_de_jogo          = (estado_q == VITORIA) || (estado_q == DERROTA);
  assign bus.vitoria              = (estado_q == VITORIA);

endmodule

// File: tb/tb_controlador_partida.sv
// Directed bench for controlador_partida: a default instance (15 attempts) and a
// second instance with MAX_TENTATIVAS=2 for the defeat path.
module tb_controlador_partida;

  logic clock;
  logic reset;
  int   passed;
  int   total;

  localparam logic [34:0] UNS      = {35{1'b1}};
  localparam logic [34:0] TAB_A    = ~(35'd1 | (35'd1 << 17));
  localparam logic [34:0] TAB_B    = ~(35'd1 << 34);
  localparam logic [34:0] PADRAO_1 = 35'h2_5A5A_5A5A;
  localparam logic [34:0] PADRAO_2 = 35'h5_0F0F_0F0F;

  controlador_partida_if bus_a ();
  controlador_partida_if bus_b ();

  controlador_partida u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus_a)
  );

  controlador_partida #(.MAX_TENTATIVAS(2)) u_dut2 (
    .clock (clock),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic atacar_a(input logic [2:0] c, input logic [2:0] l);
    bus_a.ataque_colunas = c;
    bus_a.ataque_linhas = l;
    bus_a.confirmar_ataque = 1'b1;
    tick();
    tick();
    bus_a.ataque_colunas = 3'd0;
    bus_a.ataque_linhas = 3'd0;
    bus_a.confirmar_ataque = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus_a.ligado = 1'b0; bus_a.modo = 1'b0; bus_a.salvar_jogo = 1'b0; bus_a.confirmar_ataque = 1'b0;
    bus_a.ataque_colunas = 3'd0; bus_a.ataque_linhas = 3'd0; bus_a.tabuleiro_posicionamento = UNS;
    bus_b.ligado = 1'b0; bus_b.modo = 1'b0; bus_b.salvar_jogo = 1'b0; bus_b.confirmar_ataque = 1'b0;
    bus_b.ataque_colunas = 3'd0; bus_b.ataque_linhas = 3'd0; bus_b.tabuleiro_posicionamento = UNS;
    tick(); tick();
    total++; if (bus_a.estado !== 3'd0) $display("FAIL reset_estado got %0d expected 0", bus_a.estado); else passed++;
    total++; if (bus_a.tabuleiro_saida !== UNS) $display("FAIL reset_saida got %h expected %h", bus_a.tabuleiro_saida, UNS); else passed++;
    total++; if (bus_a.tentativas_restantes !== 5'd15) $display("FAIL reset_tent got %0d expected 15", bus_a.tentativas_restantes); else passed++;
    total++; if (bus_a.ledRGB !== 2'b00 || bus_a.fim_de_jogo !== 1'b0) $display("FAIL reset_led got %b/%b expected 00/0", bus_a.ledRGB, bus_a.fim_de_jogo); else passed++;
    reset = 1'b0;
    bus_a.ligado = 1'b1;
    bus_a.tabuleiro_posicionamento = PADRAO_1;
    tick();
    total++; if (bus_a.estado !== 3'd1) $display("FAIL ligar_estado got %0d expected 1", bus_a.estado); else passed++;
    total++; if (bus_a.tabuleiro_saida !== PADRAO_1) $display("FAIL pos_saida1 got %h expected %h", bus_a.tabuleiro_saida, PADRAO_1); else passed++;
    bus_a.tabuleiro_posicionamento = PADRAO_2;
    total++; if (bus_a.tabuleiro_saida !== PADRAO_1) $display("FAIL pos_atraso got %h expected %h", bus_a.tabuleiro_saida, PADRAO_1); else passed++;
    tick();
    total++; if (bus_a.tabuleiro_saida !== PADRAO_2) $display("FAIL pos_saida2 got %h expected %h", bus_a.tabuleiro_saida, PADRAO_2); else passed++;
    total++; if (bus_a.ledRGB !== 2'b00 || bus_a.tentativas_restantes !== 5'd15) $display("FAIL pos_led_tent got %b/%0d expected 00/15", bus_a.ledRGB, bus_a.tentativas_restantes); else passed++;
  endtask

  task automatic test_sem_salvar();
    bus_a.modo = 1'b1;
    tick(); tick(); tick();
    total++; if (bus_a.estado !== 3'd1) $display("FAIL modo_sem_salvar got %0d expected 1", bus_a.estado); else passed++;
    bus_a.modo = 1'b0;
    bus_a.tabuleiro_posicionamento = UNS;
    bus_a.salvar_jogo = 1'b1;
    tick(); tick();
    bus_a.salvar_jogo = 1'b0;
    bus_a.modo = 1'b1;
    tick(); tick();
    total++; if (bus_a.estado !== 3'd1) $display("FAIL salvar_vazio got %0d expected 1", bus_a.estado); else passed++;
    bus_a.modo = 1'b0;
    tick();
  endtask

  task automatic test_salvar_e_acerto();
    bus_a.tabuleiro_posicionamento = TAB_A;
    bus_a.salvar_jogo = 1'b1;
    tick(); tick();
    bus_a.salvar_jogo = 1'b0;
    bus_a.modo = 1'b1;
    tick();
    total++; if (bus_a.estado !== 3'd2) $display("FAIL entra_ataque got %0d expected 2", bus_a.estado); else passed++;
    total++; if (bus_a.tabuleiro_saida !== UNS) $display("FAIL ataque_mapa_inicial got %h expected %h", bus_a.tabuleiro_saida, UNS); else passed++;
    bus_a.ataque_colunas = 3'd1; bus_a.ataque_linhas = 3'd1;
    bus_a.confirmar_ataque = 1'b1;
    tick(); tick();
    total++; if (bus_a.estado !== 3'd3) $display("FAIL avalia_estado got %0d expected 3", bus_a.estado); else passed++;
    bus_a.ataque_colunas = 3'd2; bus_a.ataque_linhas = 3'd2;
    bus_a.confirmar_ataque = 1'b0;
    tick();
    total++; if (bus_a.ledRGB !== 2'b10) $display("FAIL acerto_led got %b expected 10", bus_a.ledRGB); else passed++;
    total++; if (bus_a.acertos !== 6'd1 || bus_a.tentativas_restantes !== 5'd15) $display("FAIL acerto_contadores got %0d/%0d expected 1/15", bus_a.acertos, bus_a.tentativas_restantes); else passed++;
    total++; if (bus_a.tabuleiro_saida !== (UNS & ~35'd1)) $display("FAIL acerto_saida got %h expected %h", bus_a.tabuleiro_saida, UNS & ~35'd1); else passed++;
    total++; if (bus_a.estado !== 3'd2) $display("FAIL volta_ataque got %0d expected 2", bus_a.estado); else passed++;
  endtask

  task automatic test_invalidos();
    atacar_a(3'd1, 3'd1);
    total++; if (bus_a.ledRGB !== 2'b11 || bus_a.acertos !== 6'd1 || bus_a.tentativas_restantes !== 5'd15)
      $display("FAIL repetido got %b/%0d/%0d expected 11/1/15", bus_a.ledRGB, bus_a.acertos, bus_a.tentativas_restantes); else passed++;
    atacar_a(3'd2, 3'd2);
    total++; if (bus_a.ledRGB !== 2'b01 || bus_a.tentativas_restantes !== 5'd14)
      $display("FAIL agua got %b/%0d expected 01/14", bus_a.ledRGB, bus_a.tentativas_restantes); else passed++;
    atacar_a(3'd6, 3'd2);
    total++; if (bus_a.ledRGB !== 2'b11 || bus_a.acertos !== 6'd1 || bus_a.tentativas_restantes !== 5'd14)
      $display("FAIL fora_faixa got %b/%0d/%0d expected 11/1/14", bus_a.ledRGB, bus_a.acertos, bus_a.tentativas_restantes); else passed++;
    atacar_a(3'd2, 3'd2);
    total++; if (bus_a.ledRGB !== 2'b11 || bus_a.tentativas_restantes !== 5'd14)
      $display("FAIL agua_repetida got %b/%0d expected 11/14", bus_a.ledRGB, bus_a.tentativas_restantes); else passed++;
  endtask

  task automatic test_vitoria();
    atacar_a(3'd3, 3'd4);
    total++; if (bus_a.estado !== 3'd4) $display("FAIL vitoria_estado got %0d expected 4", bus_a.estado); else passed++;
    total++; if (bus_a.fim_de_jogo !== 1'b1 || bus_a.vitoria !== 1'b1) $display("FAIL vitoria_flags got %b/%b expected 1/1", bus_a.fim_de_jogo, bus_a.vitoria); else passed++;
    total++; if (bus_a.acertos !== 6'd2 || bus_a.ledRGB !== 2'b10) $display("FAIL vitoria_acertos got %0d/%b expected 2/10", bus_a.acertos, bus_a.ledRGB); else passed++;
    total++; if (bus_a.tabuleiro_saida !== TAB_A) $display("FAIL vitoria_saida got %h expected %h", bus_a.tabuleiro_saida, TAB_A); else passed++;
    atacar_a(3'd4, 3'd4);
    total++; if (bus_a.estado !== 3'd4 || bus_a.tentativas_restantes !== 5'd14 || bus_a.acertos !== 6'd2)
      $display("FAIL fim_ignora got %0d/%0d/%0d expected 4/14/2", bus_a.estado, bus_a.tentativas_restantes, bus_a.acertos); else passed++;
  endtask

  task automatic test_derrota();
    bus_b.ligado = 1'b1;
    bus_b.tabuleiro_posicionamento = TAB_B;
    tick();
    bus_b.salvar_jogo = 1'b1;
    tick(); tick();
    bus_b.salvar_jogo = 1'b0;
    bus_b.modo = 1'b1;
    tick();
    total++; if (bus_b.estado !== 3'd2 || bus_b.tentativas_restantes !== 5'd2)
      $display("FAIL d2_ataque got %0d/%0d expected 2/2", bus_b.estado, bus_b.tentativas_restantes); else passed++;
    bus_b.ataque_colunas = 3'd1; bus_b.ataque_linhas = 3'd2;
    bus_b.confirmar_ataque = 1'b1;
    for (int i = 0; i < 6; i++) tick();
    bus_b.confirmar_ataque = 1'b0;
    tick();
    total++; if (bus_b.tentativas_restantes !== 5'd1 || bus_b.ledRGB !== 2'b01 || bus_b.estado !== 3'd2)
      $display("FAIL d2_segurado got %0d/%b/%0d expected 1/01/2", bus_b.tentativas_restantes, bus_b.ledRGB, bus_b.estado); else passed++;
    bus_b.ataque_colunas = 3'd1; bus_b.ataque_linhas = 3'd3;
    bus_b.confirmar_ataque = 1'b1;
    tick(); tick();
    bus_b.confirmar_ataque = 1'b0;
    tick();
    total++; if (bus_b.tentativas_restantes !== 5'd0 || bus_b.estado !== 3'd5)
      $display("FAIL d2_derrota got %0d/%0d expected 0/5", bus_b.tentativas_restantes, bus_b.estado); else passed++;
    total++; if (bus_b.ledRGB !== 2'b01 || bus_b.fim_de_jogo !== 1'b1 || bus_b.vitoria !== 1'b0)
      $display("FAIL d2_flags got %b/%b/%b expected 01/1/0", bus_b.ledRGB, bus_b.fim_de_jogo, bus_b.vitoria); else passed++;
  endtask

  task automatic test_desligar();
    bus_a.modo = 1'b0;
    bus_a.tabuleiro_posicionamento = PADRAO_1;
    tick();
    total++; if (bus_a.estado !== 3'd1 || bus_a.ledRGB !== 2'b00 || bus_a.tabuleiro_saida !== PADRAO_1)
      $display("FAIL fim_para_pos got %0d/%b/%h expected 1/00/%h", bus_a.estado, bus_a.ledRGB, bus_a.tabuleiro_saida, PADRAO_1); else passed++;
    bus_a.modo = 1'b1;
    tick();
    total++; if (bus_a.estado !== 3'd2 || bus_a.tabuleiro_saida !== TAB_A)
      $display("FAIL progresso_mantido got %0d/%h expected 2/%h", bus_a.estado, bus_a.tabuleiro_saida, TAB_A); else passed++;
    bus_a.ataque_colunas = 3'd2; bus_a.ataque_linhas = 3'd5;
    bus_a.confirmar_ataque = 1'b1;
    tick(); tick();
    bus_a.ligado = 1'b0;
    bus_a.confirmar_ataque = 1'b0;
    tick();
    total++; if (bus_a.estado !== 3'd0 || bus_a.acertos !== 6'd0 || bus_a.tentativas_restantes !== 5'd15)
      $display("FAIL desligar_estado got %0d/%0d/%0d expected 0/0/15", bus_a.estado, bus_a.acertos, bus_a.tentativas_restantes); else passed++;
    total++; if (bus_a.ledRGB !== 2'b00 || bus_a.tabuleiro_saida !== UNS || bus_a.fim_de_jogo !== 1'b0)
      $display("FAIL desligar_saidas got %b/%h/%b expected 00/%h/0", bus_a.ledRGB, bus_a.tabuleiro_saida, bus_a.fim_de_jogo, UNS); else passed++;
    bus_a.ligado = 1'b1;
    tick();
    tick(); tick(); tick();
    total++; if (bus_a.estado !== 3'd1) $display("FAIL religar_sem_salvar got %0d expected 1", bus_a.estado); else passed++;
  endtask

  initial begin
    passed = 0;
    total = 0;
    test_reset();
    test_sem_salvar();
    test_salvar_e_acerto();
    test_invalidos();
    test_vitoria();
    test_derrota();
    test_desligar();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/controlador_partida.md
# controlador_partida

Game-flow sequencer for the 5×7 battleship board. It owns the positioning/attack/end-of-game state machine and latches the saved fleet. It evaluates each confirmed attack exactly once, tracks hits, misses and remaining attempts, and drives the column outputs and status LED. It sits between the board switches/buttons and the LED-matrix column drivers, and replaces the free-running combinational attack decode with a clocked, edge-triggered controller.

## Interface
Parameters:
- MAX_TENTATIVAS, 15: misses allowed before defeat (1..31).
- PISCA_CICLOS, 25_000_000: half-period of end-of-game blink, in clocks (used only with the macro).

Ports:
- clock  in  1  single system clock.
- reset  in  1  synchronous, active-high reset.
- ligado  in  1  power switch; 0 forces OCIOSO.
- modo  in  1  0 = positioning, 1 = attack.
- salvar_jogo  in  1  save button, level; rising edge detected internally.
- confirmar_ataque  in  1  attack button, level; rising edge detected internally.
- ataque_colunas  in  3  target column, 1..5 valid.
- ataque_linhas  in  3  target row, 1..7 valid.
- tabuleiro_posicionamento  in  35  fleet switches, active low. Bit (c-1)*7+(l-1) is column c, row l.
- tabuleiro_saida  out  35  column drive, active low, same bit mapping.
- ledRGB  out  2  00 off, 01 water, 10 hit, 11 invalid/repeated.
- estado  out  3  current FSM state code.
- acertos  out  6  hits so far.
- tentativas_restantes  out  5  misses still allowed.
- fim_de_jogo  out  1  high in VITORIA or DERROTA.
- vitoria  out  1  high in VITORIA only.

## Operation
- States:
  - OCIOSO=0: ligado=0.
  - POSICIONAMENTO=1.
  - ATAQUE=2.
  - AVALIA=3: one cycle.
  - VITORIA=4.
  - DERROTA=5.
- Reset, or ligado=0 in any state, moves to OCIOSO next clock and clears everything:
  - saved board=all 1s, hit map=all 1s, tried map=0, acertos=0, tentativas_restantes=MAX_TENTATIVAS, navios=0, jogo_salvo=0, ledRGB=00, tabuleiro_saida=all 1s.
- OCIOSO with ligado=1 goes to POSICIONAMENTO.
- POSICIONAMENTO:
  - tabuleiro_saida = tabuleiro_posicionamento (registered).
  - ledRGB=00.
  - A salvar_jogo rising edge latches the board and sets navios = count of 0 bits. It also clears the hit map, tried map and acertos, reloads tentativas_restantes and sets jogo_salvo.
  - A save with zero ship cells is ignored and jogo_salvo is unchanged.
  - modo=1 with jogo_salvo goes to ATAQUE. modo=1 without a save stays in POSICIONAMENTO.
- ATAQUE:
  - tabuleiro_saida = hit map.
  - A confirmar_ataque rising edge latches the coordinates and goes to AVALIA.
  - modo=0 returns to POSICIONAMENTO. Progress is kept until the next save.
- AVALIA decides exactly one outcome, in this priority:
  - Coordinates out of range → ledRGB=11, no counter change.
  - Cell already in the tried map → 11, no counter change.
  - Saved bit is 0 → hit: set the hit-map bit to 0, set the tried bit, acertos+1, ledRGB=10.
  - Otherwise → miss: set the tried bit, tentativas_restantes−1, ledRGB=01.
- Next state after AVALIA, using the updated values:
  - acertos==navios → VITORIA.
  - Else tentativas_restantes==0 → DERROTA.
  - Else ATAQUE.
- End states:
  - VITORIA: ledRGB=10 steady.
  - DERROTA: ledRGB=01 steady.
  - Both hold until modo=0 (→ POSICIONAMENTO), ligado=0 or reset. Button edges are ignored.
- ledRGB holds its last AVALIA value while in ATAQUE.

## Timing
- Edge detectors register the button once. The edge is seen in the cycle after the input first samples 1 with the previous sample 0.
- Confirm seen high at edge n → AVALIA at edge n+1 → counters, ledRGB and tabuleiro_saida updated at edge n+2.
- Holding a button high produces one event. A re-press needs at least one low sample.
- A save press and a mode change in the same cycle: the save is processed first. The ATAQUE transition follows on the next cycle.
- Coordinates may change after the confirm edge; the latched copy is used.
- ligado=0 or reset during AVALIA aborts the evaluation. No counter update is kept.

## Configuration
- PISCAR_FIM_EN defined:
  - In VITORIA/DERROTA, tabuleiro_saida alternates between the hit map and all 1s every PISCA_CICLOS clocks.
  - The blink counter restarts on entry to either end state.
- Undefined: the hit map is shown steadily. The counter and the PISCA_CICLOS logic are not synthesized.

## Structure
- Package pacote_batalha_naval holds:
  - State encoding.
  - LED codes LED_APAGADO/LED_AGUA/LED_ACERTO/LED_INVALIDO.
  - SETE_ALTOS, NUM_COLUNAS=5, NUM_LINHAS=7.
  - Index function (c,l) → (c-1)*7+(l-1).
- Sub-module detector_borda (rising-edge detector), instantiated for salvar_jogo and confirmar_ataque.
- Popcount and the FSM live in controlador_partida.

## Test plan
- Reset, ligado=1 → estado=1, tabuleiro_saida follows the switches one cycle late, ledRGB=00, tentativas_restantes=15.
- Save a board with ships at (1,1),(3,4); modo=1; attack (1,1) → ledRGB=10 two clocks after the edge, acertos=1, bit 0 of tabuleiro_saida=0.
- Attack (1,1) again, then (6,2) → both give ledRGB=11; acertos and tentativas_restantes unchanged.
- Attack (3,4) → VITORIA, fim_de_jogo=1, vitoria=1. Further confirm edges are ignored.
- MAX_TENTATIVAS=2, two misses → tentativas_restantes 1 then 0, estado=DERROTA, ledRGB=01.
- ligado=0 mid-game → OCIOSO next clock with all outputs at reset values. Re-enable without saving plus modo=1 → stays POSICIONAMENTO.
